// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed 7-segment driver for a chain of BCD digits.
// The digits are captured into a snapshot on load, so a counter rolling over mid-scan
// can never show half-old, half-new digits. One digit is lit at a time, each for
// SCAN_DIV cycles. Leading zeros can be blanked, and digits above 9 raise digit_err.
module bcd_display_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    digit_err
);

  // A counter must be at least one bit wide, even when it only ever holds 0.
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] snap;
  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;

  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    err_next;

  // Segment pattern {g,f,e,d,c,b,a}; codes above 9 show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Select the active snapshot digit and decide whether it is a leading zero.
  // Walking from the top digit down, upper_zero stays set while every digit seen so far
  // (including the current one) is zero; an invalid code is nonzero and stops blanking.
  always_comb begin
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    an_next    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (snap[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        cur_digit  = snap[4*i +: 4];
        cur_blank  = upper_zero && (i != 0);
        an_next[i] = 1'b1;
      end
    end
    seg_next = (blank_lz && cur_blank) ? 7'h00 : bcd_to_seg(cur_digit);
  end

  // Error flag is computed from the incoming digits so it lands together with the snapshot.
  always_comb begin
    err_next = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      err_next = err_next | (digits[4*i +: 4] > 4'd9);
    end
  end

  // Prescaler and digit index; load never touches these.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Snapshot register with its error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap      <= '0;
      digit_err <= 1'b0;
    end else if (load) begin
      snap      <= digits;
      digit_err <= err_next;
    end
  end

  // Registered display outputs, built from the pre-edge index and snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'h00;
      an  <= '0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: stimulus pushes the expected {an, seg, digit_err} for
// each clock edge into a queue; a monitor pops and compares shortly after the edge.
module tb_bcd_display_scanner;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*N-1:0] digits;
  logic           load;
  logic           blank_lz;
  logic [6:0]     seg;
  logic [N-1:0]   an;
  logic           digit_err;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   edge_n = 0;           // edges since reset release
  logic [6:0] tab[N];         // hand-computed seg for each digit position
  logic       cur_err = 1'b0;

  bcd_display_scanner #(
    .NUM_DIGITS(N),
    .SCAN_DIV  (DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digits   (digits),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("edge%0d_an", edge_n), {8'h0, an}, {8'h0, e.an});
      chk($sformatf("edge%0d_seg", edge_n), {5'h0, seg}, {5'h0, e.seg});
      chk($sformatf("edge%0d_err", edge_n), {11'h0, digit_err}, {11'h0, e.err});
    end
  end

  task automatic set_tab(input logic [6:0] t0, t1, t2, t3);
    tab[0] = t0; tab[1] = t1; tab[2] = t2; tab[3] = t3;
  endtask

  // One clock edge with the expectation for that edge queued beforehand.
  task automatic tick();
    exp_t e;
    int   i;
    i     = (edge_n / DIV) % N;
    e.an  = 4'b0001 << i;
    e.seg = tab[i];
    e.err = cur_err;
    q.push_back(e);
    @(posedge clk);
    edge_n++;
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic reset_tick();
    exp_t e;
    e = '0;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Load pulse: the load edge still shows the old snapshot, digit_err updates at once.
  task automatic load_vec(input logic [15:0] d, input logic [6:0] t0, t1, t2, t3,
                          input logic e);
    digits  = d;
    load    = 1'b1;
    cur_err = e;
    tick();
    load    = 1'b0;
    set_tab(t0, t1, t2, t3);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    digits   = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    set_tab(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    #2;
    reset_tick();
    reset_tick();
    reset  = 1'b0;
    edge_n = 0;

    // Full scan plus wrap back to digit 0, snapshot all zero.
    ticks(17);

    // Decode sweep.
    load_vec(16'h1234, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0);
    ticks(16);
    load_vec(16'h5678, 7'h7F, 7'h07, 7'h7D, 7'h6D, 1'b0);
    ticks(16);
    load_vec(16'h9090, 7'h3F, 7'h6F, 7'h3F, 7'h6F, 1'b0);
    ticks(8);

    // Leading-zero blanking (top digit of 9090 is nonzero, so nothing blanks yet).
    blank_lz = 1'b1;
    ticks(4);
    load_vec(16'h0905, 7'h6D, 7'h3F, 7'h6F, 7'h00, 1'b0);
    ticks(16);
    load_vec(16'h0000, 7'h3F, 7'h00, 7'h00, 7'h00, 1'b0);
    ticks(16);

    // Invalid digit counts as nonzero for blanking and shows a dash.
    load_vec(16'h0A00, 7'h3F, 7'h3F, 7'h40, 7'h00, 1'b1);
    ticks(16);
    load_vec(16'h0012, 7'h5B, 7'h06, 7'h00, 7'h00, 1'b0);
    ticks(16);

    // blank_lz toggle takes effect on the next edge.
    blank_lz = 1'b0;
    set_tab(7'h5B, 7'h06, 7'h3F, 7'h3F);
    ticks(8);

    // Tear-free snapshot: digits move without load, display holds.
    load_vec(16'h1111, 7'h06, 7'h06, 7'h06, 7'h06, 1'b0);
    digits = 16'h2222;
    ticks(16);
    for (int k = 0; k < 16; k++) begin
      if (((edge_n / DIV) % N) == 2 && (edge_n % DIV) == 1) break;
      tick();
    end
    load_vec(16'h2222, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 1'b0);
    ticks(8);
    load_vec(16'h2F22, 7'h5B, 7'h5B, 7'h40, 7'h5B, 1'b1);

    // Async reset between edges while digit 2 is lit.
    for (int k = 0; k < 16; k++) begin
      if (((edge_n - 1) / DIV) % N == 2) break;
      tick();
    end
    reset = 1'b1;
    #1;
    chk("async_rst_an", {8'h0, an}, 12'h0);
    chk("async_rst_seg", {5'h0, seg}, 12'h0);
    chk("async_rst_err", {11'h0, digit_err}, 12'h0);
    #1;
    reset_tick();
    reset   = 1'b0;
    edge_n  = 0;
    cur_err = 1'b0;
    set_tab(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    ticks(6);

    chk("queue_drained", 12'(q.size()), 12'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
